// File: rtl/funct_generator_wave_gen.sv
// Waveform sample source: a tick divider paces sawtooth, triangle, square and
// ramp-down samples onto a valid/ready handshake feeding the holding register.
module funct_generator_wave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            wave_sel,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic                  sample_ready,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  clr_out
);

  typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;

  localparam logic [DATA_WIDTH-1:0] MAX     = '1;
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] WAVE_SAW  = 2'd0;
  localparam logic [1:0] WAVE_TRI  = 2'd1;
  localparam logic [1:0] WAVE_SQR  = 2'd2;

  state_t                state_reg, state_next;
  logic [1:0]            wave_reg, wave_next;
  logic [DIV_WIDTH-1:0]  div_reg, div_next;
  logic [DIV_WIDTH-1:0]  div_cnt_reg, div_cnt_next;
  logic [DATA_WIDTH-1:0] step_reg, step_next;
  logic [DATA_WIDTH-1:0] phase_reg, phase_next;
  logic [DATA_WIDTH-1:0] tri_reg, tri_next;
  logic                  tri_down_reg, tri_down_next;
  logic [DATA_WIDTH-1:0] sample_reg, sample_next;
  logic                  valid_reg, valid_next;
  logic                  clr_reg, clr_next;

  logic [DATA_WIDTH-1:0] ramp_val;
  logic [DATA_WIDTH-1:0] square_val;
  logic [DATA_WIDTH-1:0] mapped_val;

  // MAX-phase is simply the bitwise complement; square replicates the phase MSB.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_map
      assign ramp_val[gi]   = ~phase_reg[gi];
      assign square_val[gi] = phase_reg[DATA_WIDTH-1];
    end
  endgenerate

  always_comb begin
    case (wave_reg)
      WAVE_SAW: mapped_val = phase_reg;
      WAVE_TRI: mapped_val = tri_reg;
      WAVE_SQR: mapped_val = square_val;
      default:  mapped_val = ramp_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wave_reg     <= '0;
      div_reg      <= DIV_ONE;
      div_cnt_reg  <= '0;
      step_reg     <= '0;
      phase_reg    <= '0;
      tri_reg      <= '0;
      tri_down_reg <= 1'b0;
      sample_reg   <= '0;
      valid_reg    <= 1'b0;
      clr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wave_reg     <= wave_next;
      div_reg      <= div_next;
      div_cnt_reg  <= div_cnt_next;
      step_reg     <= step_next;
      phase_reg    <= phase_next;
      tri_reg      <= tri_next;
      tri_down_reg <= tri_down_next;
      sample_reg   <= sample_next;
      valid_reg    <= valid_next;
      clr_reg      <= clr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wave_next     = wave_reg;
    div_next      = div_reg;
    div_cnt_next  = div_cnt_reg;
    step_next     = step_reg;
    phase_next    = phase_reg;
    tri_next      = tri_reg;
    tri_down_next = tri_down_reg;
    sample_next   = sample_reg;
    valid_next    = valid_reg;
    clr_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          wave_next     = wave_sel;
          div_next      = (divisor == '0) ? DIV_ONE : divisor;
          step_next     = step;
          phase_next    = '0;
          tri_next      = '0;
          tri_down_next = 1'b0;
          div_cnt_next  = '0;
          clr_next      = 1'b1;
          state_next    = COUNT;
        end
      end
      COUNT: begin
        if (stop) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (div_cnt_reg == div_reg - DIV_ONE) begin
          div_cnt_next = '0;
          sample_next  = mapped_val;
          valid_next   = 1'b1;
          state_next   = EMIT;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_ONE;
        end
      end
      EMIT: begin
        // A stop drops the pending sample even when ready is high.
        if (stop) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end else if (sample_ready) begin
          valid_next = 1'b0;
          phase_next = phase_reg + step_reg;
          // Compare against MAX-step / step so the triangle never overflows.
          if (!tri_down_reg) begin
            if (tri_reg > (MAX - step_reg)) begin
              tri_next      = MAX;
              tri_down_next = 1'b1;
            end else begin
              tri_next = tri_reg + step_reg;
            end
          end else begin
            if (tri_reg < step_reg) begin
              tri_next      = '0;
              tri_down_next = 1'b0;
            end else begin
              tri_next = tri_reg - step_reg;
            end
          end
          state_next = COUNT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sample       = sample_reg;
  assign sample_valid = valid_reg;
  assign busy         = (state_reg != IDLE);
  assign clr_out      = clr_reg;

endmodule

// File: doc/funct_generator_wave_gen.md
# funct_generator_wave_gen

Waveform sample source for the function generator datapath. It sits directly upstream of the 8-bit holding register and the sample FIFO. From a programmable tick divider it produces sawtooth, ramp-down, square or triangle samples and delivers them over a valid/ready handshake. `sample_valid` drives the register's load enable, and `clr_out` clears the register when a new run starts.

## Interface
- `DATA_WIDTH`, 8: sample, phase and step width.
- `DIV_WIDTH`, 16: divisor and divider counter width.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  starts a run; ignored while `busy`=1.
- `stop`  in  1  aborts the run; wins over `start` when both are high.
- `wave_sel`  in  2  waveform select: 0 sawtooth, 1 triangle, 2 square, 3 ramp-down. Latched on start.
- `divisor`  in  DIV_WIDTH  clock cycles per tick. Latched on start; a value of 0 is treated as 1.
- `step`  in  DATA_WIDTH  phase increment per accepted sample. Latched on start.
- `sample_ready`  in  1  downstream can accept a sample.
- `sample`  out  DATA_WIDTH  sample value.
- `sample_valid`  out  1  `sample` is valid; drives the downstream register enable.
- `busy`  out  1  high when not IDLE.
- `clr_out`  out  1  one-cycle pulse on an accepted start; clears the downstream register.

## Operation
- Reset values: `sample`=0, `sample_valid`=0, `busy`=0, `clr_out`=0. Internal reset: state IDLE, phase=0, tri=0, tri_dir=up, div_cnt=0.
- FSM states:
  - IDLE: `start`=1 and `stop`=0 latches `wave_sel`, `divisor` and `step`; sets phase=0, tri=0, tri_dir=up, div_cnt=0; pulses `clr_out`; goes to COUNT.
  - COUNT: div_cnt increments each cycle. When div_cnt == div_l-1: div_cnt←0, `sample` is loaded from the current phase/tri, `sample_valid`←1, go to EMIT.
  - EMIT: `sample_valid` and `sample` are held stable while `sample_ready`=0. When `sample_ready`=1: `sample_valid`←0, phase/tri advance, go to COUNT.
- `stop`=1 in COUNT or EMIT: next state is IDLE and `sample_valid`←0. `sample` keeps its last value. A sample pending in EMIT is dropped, even if `sample_ready`=1 in the same cycle.
- Sample mapping, with MAX = 2^DATA_WIDTH-1:
  - sawtooth: phase.
  - ramp-down: MAX-phase.
  - square: phase MSB ? MAX : 0.
  - triangle: tri.
- Phase advance: phase←(phase+step) mod 2^DATA_WIDTH, with natural wrap.
- Triangle advance:
  - Going up: if tri > MAX-step then tri←MAX and tri_dir←down; else tri←tri+step.
  - Going down: if tri < step then tri←0 and tri_dir←up; else tri←tri-step.
  - The sum is never wider than DATA_WIDTH; the comparisons avoid overflow.
- `step`=0 is legal and produces a constant output.
- `busy` = (state != IDLE).
- `wave_sel`, `divisor` and `step` changes during a run have no effect until the next start.

## Timing
- `start` sampled at edge E0 → `clr_out`=1 and `busy`=1 during cycle E0..E1.
- First `sample_valid`=1 appears after edge E0+div_l.
- With `sample_ready` held high, each valid pulse lasts one cycle and the sample period is div_l+1 cycles.
- Handshake: a transfer occurs on an edge where `sample_valid` & `sample_ready` = 1. Valid never drops without a transfer, except on `stop` or `rst`.
- `rst` mid-run → all outputs return to their reset values at the next edge, regardless of state or other inputs.
- `start` and `stop` high together in IDLE → stay in IDLE, no `clr_out`.
- Latency from an accept to the next value: div_l cycles.

## Test plan
- Sawtooth, `step`=1, `divisor`=1, `sample_ready`=1 → samples 0,1,2,… with valid high every 2nd cycle; sample 256 wraps 0xFF→0x00. `clr_out` pulses once at start.
- Triangle, `step`=100, `divisor`=3 → sequence 0,100,200,255,155,55,0,100. Valid period is 4 cycles.
- Square, `step`=64 → 0,0,255,255,0. Ramp-down with `step`=1 → 255,254,253.
- Backpressure: sawtooth with `sample_ready` low for 5 cycles while valid → valid and `sample` held stable for 5 cycles. The next sample after the accept is the previous value+step; nothing is skipped or duplicated.
- `stop` during EMIT with `sample_ready`=1 → no transfer, IDLE next cycle, valid=0, `sample` unchanged. `start`+`stop` together in IDLE → `busy` stays 0.
- `divisor`=0 behaves as 1. `start` while `busy` is ignored (the latched `step` is unchanged). `rst` asserted mid-EMIT → `sample`=0, valid=0, `busy`=0 next edge; a following start gives first sample 0.
